// File: rtl/idma_desc64_writer.sv
// idma_desc64_writer: encodes iDMA backend requests into 256-bit descriptors and
// writes them as four 64-bit beats into a ring of 32-byte descriptor slots.
// Optional request checking is enabled with IDMA_DESC64_WRITER_CHECK_EN.

package idma_desc64_writer_pkg;

  typedef struct packed {
    logic [1:0] burst;
    logic [3:0] cache;
    logic       lock;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } axi_opt_t;

  typedef struct packed {
    logic       decouple_aw;
    logic       decouple_rw;
    logic [2:0] src_max_llen;
    logic [2:0] dst_max_llen;
    logic       src_reduce_len;
    logic       dst_reduce_len;
  } be_opt_t;

  typedef struct packed {
    logic [2:0] src_protocol;
    logic [2:0] dst_protocol;
    logic [7:0] axi_id;
    axi_opt_t   src;
    axi_opt_t   dst;
    be_opt_t    beo;
    logic       last;
  } options_t;

  typedef struct packed {
    logic [63:0] length;
    logic [63:0] src_addr;
    logic [63:0] dst_addr;
    options_t    opt;
  } idma_req_t;

endpackage

module idma_desc64_writer #(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned NumSlots   = 4,
  parameter type         idma_req_t = idma_desc64_writer_pkg::idma_req_t,
  parameter type         addr_t     = logic [AddrWidth-1:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  addr_t                      ring_base_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  idma_req_t                  req_i,
  input  logic                       irq_i,
  input  logic                       last_i,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output addr_t                      mem_addr_o,
  output logic [63:0]                mem_wdata_o,
  output logic [7:0]                 mem_strb_o,
  output logic                       desc_done_o,
  output addr_t                      desc_addr_o,
  input  logic                       release_i,
  output logic [$clog2(NumSlots):0]  used_o,
  output logic                       err_o
);

  localparam int unsigned IdxW = $clog2(NumSlots);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(NumSlots);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   used_q, used_d;
  addr_t             ring_base_q, ring_base_d;
  logic [31:0]       length_q, length_d;
  logic [31:0]       flags_q, flags_d;
  logic [63:0]       src_q, src_d;
  logic [63:0]       dst_q, dst_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic              accept;
  logic              bad;
  logic              inc;
  logic              dec;
  logic [31:0]       flags_in;
  logic [IdxW-1:0]   idx_nxt;
  addr_t             slot_base;
  addr_t             slot_next;
  logic              unused_req;

  // Only part of the request is encoded; the remaining option bits are dropped.
  assign unused_req = ^req_i;

  assign mem_strb_o = 8'hFF;
  assign used_o     = used_q;

  // DONE also accepts so a new descriptor can start every five cycles; a release
  // in the same cycle already frees the slot for that accept.
  assign req_ready_o = ((state_q == IDLE) || (state_q == DONE)) &&
                       ((used_q < FullCnt) || release_i);
  assign accept      = req_valid_i && req_ready_o;

`ifdef IDMA_DESC64_WRITER_CHECK_EN
  assign bad = (req_i.opt.beo.src_reduce_len != req_i.opt.beo.dst_reduce_len) ||
               (|req_i.opt.beo.src_max_llen) || (|req_i.opt.beo.dst_max_llen);
  assign err_o = err_q;
`else
  assign bad   = 1'b0;
  assign err_o = 1'b0;
`endif

  assign inc = accept && !bad;
  assign dec = release_i && (used_q != '0);

  // Pack the incoming request options into the descriptor flags word.
  always_comb begin
    flags_in        = '0;
    flags_in[0]     = irq_i;
    flags_in[2:1]   = req_i.opt.src.burst;
    flags_in[4:3]   = req_i.opt.dst.burst;
    flags_in[5]     = req_i.opt.beo.decouple_rw;
    flags_in[6]     = req_i.opt.beo.decouple_aw;
    flags_in[7]     = req_i.opt.beo.src_reduce_len;
    flags_in[11:8]  = req_i.opt.src.cache;
    flags_in[15:12] = req_i.opt.dst.cache;
    flags_in[23:16] = req_i.opt.axi_id;
    flags_in[26:24] = req_i.opt.src_protocol;
    flags_in[29:27] = req_i.opt.dst_protocol;
  end

  // Next-state logic: beat sequencing, ring index, slot occupancy and request capture.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    used_d      = used_q;
    ring_base_d = ring_base_q;
    length_d    = length_q;
    flags_d     = flags_q;
    src_d       = src_q;
    dst_d       = dst_q;
    last_d      = last_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: ;
      WRITE: begin
        if (mem_gnt_i) begin
          if (beat_q == 2'd3) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      DONE: begin
        idx_d   = idx_q + IdxW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A rejected request is consumed without touching slot state.
    if (accept) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        state_d     = WRITE;
        beat_d      = '0;
        ring_base_d = ring_base_i;
        length_d    = req_i.length[31:0];
        flags_d     = flags_in;
        src_d       = req_i.src_addr;
        dst_d       = req_i.dst_addr;
        last_d      = last_i;
      end
    end

    case ({inc, dec})
      2'b10:   used_d = used_q + CntW'(1);
      2'b01:   used_d = used_q - CntW'(1);
      default: used_d = used_q;
    endcase
  end

  // Slot addressing for the descriptor currently held in the registers.
  always_comb begin
    idx_nxt   = idx_q + IdxW'(1);
    slot_base = ring_base_q + (AddrWidth'(idx_q) << 5);
    slot_next = ring_base_q + (AddrWidth'(idx_nxt) << 5);
  end

  // Memory beat and completion outputs, driven to zero outside their states.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    desc_done_o = 1'b0;
    desc_addr_o = '0;
    case (state_q)
      WRITE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = slot_base + (AddrWidth'(beat_q) << 3);
        case (beat_q)
          2'd0:    mem_wdata_o = last_q ? '1 : 64'(slot_next);
          2'd1:    mem_wdata_o = {flags_q, length_q};
          2'd2:    mem_wdata_o = src_q;
          default: mem_wdata_o = dst_q;
        endcase
      end
      DONE: begin
        desc_done_o = 1'b1;
        desc_addr_o = slot_base;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      idx_q       <= '0;
      used_q      <= '0;
      ring_base_q <= '0;
      length_q    <= '0;
      flags_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      used_q      <= used_d;
      ring_base_q <= ring_base_d;
      length_q    <= length_d;
      flags_q     <= flags_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

endmodule
